// File: rtl/response_buffer_if.sv
// response_buffer_if: response path bundle between shared_resource, response_buffer and consumer
// Ports (slave = buffer side):
//   in_issue, in_data, in_id, in_valid, in_stall             -> into the buffer
//   out_credit, out_data, out_id, out_valid, out_count,
//   out_overflow, out_underflow                              <- out of the buffer
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
interface response_buffer_if #(
  parameter int DEPTH = 4,
  parameter int DATA_W = `DATA_WIDTH,
  parameter int ID_W = `ID_WIDTH
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic in_issue;
  logic in_valid;
  logic in_stall;
  logic [DATA_W-1:0] in_data;
  logic [ID_W-1:0] in_id;
  logic out_credit;
  logic out_valid;
  logic out_overflow;
  logic out_underflow;
  logic [DATA_W-1:0] out_data;
  logic [ID_W-1:0] out_id;
  logic [CNT_W-1:0] out_count;
  modport slave (
    input in_issue, in_valid, in_stall, in_data, in_id,
    output out_credit, out_valid, out_overflow, out_underflow, out_data, out_id, out_count
  );
  modport master (
    output in_issue, in_valid, in_stall, in_data, in_id,
    input out_credit, out_valid, out_overflow, out_underflow, out_data, out_id, out_count
  );
endinterface

// File: rtl/response_buffer.sv
// response_buffer: non-stallable response capture FIFO with credit-based issue throttling
// Ports: clk, reset (sync, active-low), bus (response_buffer_if.slave):
//   in_issue/in_valid/in_data/in_id from the resource, in_stall from the consumer,
//   out_credit to the arbiter, out_valid/out_data/out_id/out_count to the consumer,
//   out_overflow/out_underflow sticky error flags.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
module response_buffer #(
  parameter int DEPTH = 4,
  parameter int DATA_W = `DATA_WIDTH,
  parameter int ID_W = `ID_WIDTH
) (
  input logic clk,
  input logic reset,
  response_buffer_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ID_W-1:0] id_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, inflight, count_nxt, inflight_nxt;
  logic [CNT_W:0] reserved;
  logic credit, pop, push, issue_ok, retire, overflow, underflow;
  // A response arriving in the same cycle as an accepted issue retires that
  // issue, so inflight only decrements when there is something to retire.
  always_comb begin
    reserved = {1'b0, count} + {1'b0, inflight};
    credit = reserved < (CNT_W + 1)'(DEPTH);
    pop = (count != '0) & ~bus.in_stall;
    push = bus.in_valid & ((count < CNT_W'(DEPTH)) | pop);
    issue_ok = bus.in_issue & credit;
    retire = bus.in_valid & ((inflight != '0) | issue_ok);
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    inflight_nxt = inflight + CNT_W'(issue_ok) - CNT_W'(retire);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      inflight <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        id_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= bus.in_data;
        id_mem[wr_ptr] <= bus.in_id;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      inflight <= inflight_nxt;
      overflow <= overflow | (bus.in_valid & ~push) | (bus.in_issue & ~credit);
      underflow <= underflow | (bus.in_valid & (inflight == '0) & ~issue_ok);
    end
  end
  assign bus.out_data = data_mem[rd_ptr];
  assign bus.out_id = id_mem[rd_ptr];
  assign bus.out_valid = count != '0;
  assign bus.out_count = count;
  assign bus.out_credit = credit;
  assign bus.out_overflow = overflow;
  assign bus.out_underflow = underflow;
endmodule

// File: tb/tb_response_buffer.sv
// tb_response_buffer: randomized scoreboard bench for response_buffer
module tb_response_buffer;
  localparam int DEPTH = 4;
  localparam int DW = 8;
  localparam int IW = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  response_buffer_if #(.DEPTH(DEPTH), .DATA_W(DW), .ID_W(IW)) bus ();
  response_buffer #(.DEPTH(DEPTH), .DATA_W(DW), .ID_W(IW)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [IW+DW-1:0] sb [$];
  int mcount = 0;
  int minf = 0;
  bit movf = 1'b0;
  bit mudf = 1'b0;
  bit mcleared = 1'b0;
  bit started = 1'b0;
  logic m_credit, m_pop, m_acc, m_iok;
  assign m_credit = (mcount + minf) < DEPTH;
  assign m_pop = (mcount != 0) && !bus.in_stall;
  assign m_acc = bus.in_valid && ((mcount < DEPTH) || m_pop);
  assign m_iok = bus.in_issue && m_credit;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: occupancy, requests outstanding, sticky errors; accepted responses go to the scoreboard.
  always @(posedge clk) begin
    started <= 1'b1;
    if (!reset) begin
      mcount <= 0;
      minf <= 0;
      movf <= 1'b0;
      mudf <= 1'b0;
      mcleared <= 1'b1;
      sb.delete();
    end else begin
      mcleared <= 1'b0;
      if (m_acc) sb.push_back({bus.in_id, bus.in_data});
      mcount <= mcount + int'(m_acc) - int'(m_pop);
      minf <= minf + int'(m_iok) - int'(bus.in_valid && (minf > 0 || m_iok));
      if ((bus.in_valid && !m_acc) || (bus.in_issue && !m_credit)) movf <= 1'b1;
      if (bus.in_valid && minf == 0 && !m_iok) mudf <= 1'b1;
    end
  end
  always @(negedge clk) if (started) begin
    chk("count", bus.out_count, mcount);
    chk("valid", bus.out_valid, mcount != 0);
    chk("credit", bus.out_credit, (mcount + minf) < DEPTH);
    chk("overflow", bus.out_overflow, movf);
    chk("underflow", bus.out_underflow, mudf);
    if (mcleared) begin
      chk("rst_data", bus.out_data, 0);
      chk("rst_id", bus.out_id, 0);
    end
  end
  // Monitor: every head the consumer takes must be the oldest expected response.
  always @(negedge clk) if (reset && bus.out_valid && !bus.in_stall) begin
    logic [IW+DW-1:0] e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL head_pop: got id %0d data %0d expected no entry at %0t", bus.out_id, bus.out_data, $time);
    end else begin
      e = sb.pop_front();
      chk("head_id", bus.out_id, e[DW+:IW]);
      chk("head_data", bus.out_data, e[DW-1:0]);
    end
  end
  task automatic drive(input bit iss, input bit vld, input bit stl, input logic [IW-1:0] id, input logic [DW-1:0] d);
    bus.in_issue = iss;
    bus.in_valid = vld;
    bus.in_stall = stl;
    bus.in_id = id;
    bus.in_data = d;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n, input bit stl);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, stl, '0, '0);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    idle(1, 1'b0);
    reset = 1'b1;
  endtask
  initial begin
    bus.in_issue = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_stall = 1'b0;
    bus.in_id = '0;
    bus.in_data = '0;
    drive(1'b0, 1'b1, 1'b0, 4'd3, 8'h11);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 8'h11);
    reset = 1'b1;
    chk("t1_valid", bus.out_valid, 0);
    chk("t1_count", bus.out_count, 0);
    chk("t1_credit", bus.out_credit, 1);
    chk("t1_flags", {bus.out_overflow, bus.out_underflow}, 0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    idle(1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd1, 8'hA5);
    chk("t2_valid", bus.out_valid, 1);
    chk("t2_data", bus.out_data, 8'hA5);
    chk("t2_id", bus.out_id, 1);
    idle(1, 1'b0);
    chk("t2_count", bus.out_count, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, '0, '0);
    chk("t3_credit", bus.out_credit, 0);
    drive(1'b1, 1'b0, 1'b1, '0, '0);
    chk("t3_overflow", bus.out_overflow, 1);
    chk("t3_credit_held", bus.out_credit, 0);
    do_reset();
    chk("t3_rst_overflow", bus.out_overflow, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, IW'(i), DW'($urandom));
    chk("t4_full", bus.out_count, 4);
    drive(1'b0, 1'b1, 1'b0, 4'd4, DW'($urandom));
    chk("t4_count", bus.out_count, 4);
    chk("t4_no_overflow", bus.out_overflow, 0);
    idle(6, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 8 && !m_credit; k++) idle(1, 1'b0);
      drive(1'b1, 1'b0, ($urandom % 2) == 1, '0, '0);
      drive(1'b0, 1'b1, ($urandom % 2) == 1, IW'(i), DW'($urandom));
    end
    idle(6, 1'b0);
    chk("t5_flags", {bus.out_overflow, bus.out_underflow}, 0);
    chk("t5_drained", sb.size(), 0);
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 4'd7, 8'h3C);
    chk("t6_underflow", bus.out_underflow, 1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, IW'(8 + i), DW'($urandom));
    drive(1'b0, 1'b1, 1'b1, 4'd15, 8'hEE);
    chk("t6_overflow", bus.out_overflow, 1);
    chk("t6_count", bus.out_count, 4);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, ($urandom % 2) == 1, IW'($urandom), DW'($urandom));
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'd2, 8'h77);
    reset = 1'b1;
    chk("t6_rst_count", bus.out_count, 0);
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_credit", bus.out_credit, 1);
    chk("t6_rst_flags", {bus.out_overflow, bus.out_underflow}, 0);
    for (int i = 0; i < 400; i++) begin
      bit iss;
      iss = (($urandom % 2) == 1) && m_credit;
      drive(iss, (minf > 0) && (($urandom % 3) != 0), ($urandom % 4) == 0, IW'($urandom), DW'($urandom));
    end
    idle(6, 1'b0);
    chk("rand_clean_flags", {bus.out_overflow, bus.out_underflow}, 0);
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom % 40) != 0;
      drive(($urandom % 2) == 1, ($urandom % 2) == 1, ($urandom % 3) == 0, IW'($urandom), DW'($urandom));
    end
    reset = 1'b1;
    idle(6, 1'b0);
    chk("final_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
